skein_subkey_gen: RTL and testbench

Sequential Threefish key-schedule engine for the Skein datapath. It accepts one key block and one 128-bit tweak, then computes the parity key word and tweak word t2. It then streams every subkey sk[s], s = 0..NUM_SUBKEYS-1, over a valid/ready handshake to the round pipeline. It replaces per-round combinational subkey logic: a rotating key ring and tweak ring remove all modulo indexing.

---
 rtl/skein_pkg.sv | 14 +
 rtl/skein_subkey_inject.sv | 23 ++
 rtl/skein_subkey_gen.sv | 113 +++++++++++
 tb/tb_skein_subkey_gen.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/skein_pkg.sv
// Shared constants and types for the Skein/Threefish key schedule.
package skein_pkg;

  localparam int          WORD_W = 64;
  localparam logic [63:0] C240   = 64'h1BD11BDAA9FC1A22;

  typedef enum logic [1:0] {IDLE, PREP, EMIT} state_t;

  // Threefish-1024 runs 20 rounds-of-4 (21 subkeys); the smaller widths run 18 (19 subkeys).
  function automatic int default_subkeys(input int nw);
    return (nw == 16) ? 21 : 19;
  endfunction

endpackage

// File: rtl/skein_subkey_inject.sv
// Combinational subkey injection: the three top key words pick up the two
// tweak words and the subkey index; the remaining words pass straight through.
module skein_subkey_inject
  import skein_pkg::*;
#(
  parameter int NW = 4
) (
  input  logic [NW-1:0][WORD_W-1:0] words_in,
  input  logic [WORD_W-1:0]         tw_a,
  input  logic [WORD_W-1:0]         tw_b,
  input  logic [WORD_W-1:0]         s_word,
  output logic [NW-1:0][WORD_W-1:0] words_out
);

  // Word NW-3 gets tw_a, NW-2 gets tw_b, NW-1 gets the index.
  always_comb begin
    words_out         = words_in;
    words_out[NW-3]   = words_in[NW-3] + tw_a;
    words_out[NW-2]   = words_in[NW-2] + tw_b;
    words_out[NW-1]   = words_in[NW-1] + s_word;
  end

endmodule

// File: rtl/skein_subkey_gen.sv
// Sequential Threefish key-schedule engine. A key ring of NW+1 words and a
// tweak ring of 3 words rotate by one per accepted subkey, so the subkey for
// index s is always read from fixed ring positions with no modulo logic.
module skein_subkey_gen
  import skein_pkg::*;
#(
  parameter int NW          = 4,
  parameter int NUM_SUBKEYS = default_subkeys(NW),
  parameter int SW          = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_valid,
  output logic                 load_ready,
  input  logic [NW*WORD_W-1:0] key_in,
  input  logic [127:0]         tweak_in,
  input  logic                 abort,
  output logic                 sk_valid,
  input  logic                 sk_ready,
  output logic [NW*WORD_W-1:0] sk_out,
  output logic [SW-1:0]        sk_index,
  output logic                 sk_last,
  output logic                 busy
);

  if (!(NW == 4 || NW == 8 || NW == 16)) begin : g_bad_nw
    $error("skein_subkey_gen: NW must be 4, 8 or 16");
  end
  if ((1 << SW) < NUM_SUBKEYS) begin : g_bad_sw
    $error("skein_subkey_gen: SW too narrow for NUM_SUBKEYS");
  end

  localparam logic [SW-1:0] LAST = SW'(NUM_SUBKEYS - 1);

  state_t                      state;
  logic [SW-1:0]               s;
  logic [NW:0][WORD_W-1:0]     ring;
  logic [2:0][WORD_W-1:0]      tring;
  logic [WORD_W-1:0]           parity;
  logic [NW-1:0][WORD_W-1:0]   inj_out;
  logic                        emit;
  logic                        hs;

  assign emit = (state == EMIT);
  assign hs   = emit && sk_ready;

  // Parity word over the latched key words, used once in PREP.
  always_comb begin
    parity = C240;
    for (int i = 0; i < NW; i++) parity = parity ^ ring[i];
  end

  // FSM plus key/tweak rings; rings rotate left on every accepted subkey.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      s     <= '0;
      ring  <= '0;
      tring <= '0;
    end else begin
      case (state)
        IDLE: if (load_valid) begin
          for (int i = 0; i < NW; i++)
            ring[i] <= key_in[NW*WORD_W-1-WORD_W*i -: WORD_W];
          tring[0] <= tweak_in[127:64];
          tring[1] <= tweak_in[63:0];
          s        <= '0;
          state    <= PREP;
        end
        PREP: if (abort) begin
          state <= IDLE;
        end else begin
          ring[NW] <= parity;
          tring[2] <= tring[0] ^ tring[1];
          state    <= EMIT;
        end
        EMIT: begin
          if (sk_ready) begin
            for (int j = 0; j < NW; j++) ring[j] <= ring[j+1];
            ring[NW] <= ring[0];
            tring    <= {tring[0], tring[2], tring[1]};
            s        <= s + 1'b1;
          end
          // A transfer coinciding with abort still completes; nothing follows it.
          if (abort || (hs && s == LAST)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  skein_subkey_inject #(.NW(NW)) u_inject (
    .words_in  (ring[NW-1:0]),
    .tw_a      (tring[0]),
    .tw_b      (tring[1]),
    .s_word    ({{(WORD_W-SW){1'b0}}, s}),
    .words_out (inj_out)
  );

  // Outputs are gated by state so nothing leaks outside EMIT.
  always_comb begin
    sk_out = '0;
    for (int i = 0; i < NW; i++)
      sk_out[NW*WORD_W-1-WORD_W*i -: WORD_W] = emit ? inj_out[i] : '0;
  end

  assign load_ready = (state == IDLE);
  assign busy       = (state != IDLE);
  assign sk_valid   = emit;
  assign sk_index   = emit ? s : '0;
  assign sk_last    = emit && (s == LAST);

endmodule

// File: tb/tb_skein_subkey_gen.sv
// Scoreboard bench for skein_subkey_gen: NW=4 and NW=8 instances, a
// specification-level reference model, and per-instance output monitors.
module tb_skein_subkey_gen;

  localparam logic [63:0] C240 = 64'h1BD11BDAA9FC1A22;

  typedef logic [63:0] karr_t [16];
  typedef struct {
    logic [511:0] sk;
    int           idx;
    bit           last;
  } exp_t;

  logic         clk = 0;
  logic         rst = 1;
  int           checks = 0;
  int           errors = 0;
  exp_t         q4[$];
  exp_t         q8[$];
  exp_t         e4, e8;

  // NW=4 instance
  logic         lv4 = 0, lr4, ab4 = 0, v4, rdy4 = 0, l4, b4;
  logic [255:0] key4 = '0, o4;
  logic [127:0] tw4 = '0;
  logic [4:0]   i4;
  // NW=8 instance
  logic         lv8 = 0, lr8, ab8 = 0, v8, rdy8 = 0, l8, b8;
  logic [511:0] key8 = '0, o8;
  logic [127:0] tw8 = '0;
  logic [4:0]   i8;

  always #5 clk = ~clk;

  skein_subkey_gen #(.NW(4), .NUM_SUBKEYS(19), .SW(5)) dut4 (
    .clk(clk), .rst(rst), .load_valid(lv4), .load_ready(lr4), .key_in(key4),
    .tweak_in(tw4), .abort(ab4), .sk_valid(v4), .sk_ready(rdy4), .sk_out(o4),
    .sk_index(i4), .sk_last(l4), .busy(b4));

  skein_subkey_gen #(.NW(8), .NUM_SUBKEYS(19), .SW(5)) dut8 (
    .clk(clk), .rst(rst), .load_valid(lv8), .load_ready(lr8), .key_in(key8),
    .tweak_in(tw8), .abort(ab8), .sk_valid(v8), .sk_ready(rdy8), .sk_out(o8),
    .sk_index(i8), .sk_last(l8), .busy(b8));

  task automatic check(input string nm, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", nm, got, exp);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s", nm);
  endtask

  // Reference: sk[s] word i = k[(s+i) mod (NW+1)] plus tweak / index terms.
  function automatic logic [511:0] ref_sk(input int nw, input karr_t k,
                                          input logic [63:0] t0, input logic [63:0] t1,
                                          input int s);
    logic [63:0]  kk [17];
    logic [63:0]  t  [3];
    logic [63:0]  w;
    logic [511:0] r = '0;
    kk[nw] = C240;
    for (int i = 0; i < nw; i++) begin
      kk[i]  = k[i];
      kk[nw] = kk[nw] ^ k[i];
    end
    t[0] = t0; t[1] = t1; t[2] = t0 ^ t1;
    for (int i = 0; i < nw; i++) begin
      w = kk[(s + i) % (nw + 1)];
      if (i == nw - 3) w = w + t[s % 3];
      if (i == nw - 2) w = w + t[(s + 1) % 3];
      if (i == nw - 1) w = w + 64'(s);
      r[(nw-1-i)*64 +: 64] = w;
    end
    return r;
  endfunction

  task automatic push_exp(input bit w8, input int nw, input karr_t k,
                          input logic [63:0] t0, input logic [63:0] t1);
    exp_t e;
    for (int s = 0; s < 19; s++) begin
      e.sk = ref_sk(nw, k, t0, t1, s);
      e.idx = s;
      e.last = (s == 18);
      if (w8) q8.push_back(e); else q4.push_back(e);
    end
  endtask

  function automatic karr_t rnd_k();
    karr_t r;
    for (int i = 0; i < 16; i++) r[i] = {$urandom, $urandom};
    return r;
  endfunction

  // Monitors: every accepted subkey must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && v4 && rdy4) begin
      if (q4.size() == 0) fail("sb4_unexpected_subkey");
      else begin
        e4 = q4.pop_front();
        check("sk4", {256'b0, o4}, e4.sk);
        check("idx4", 512'(i4), 512'(e4.idx));
        check("last4", 512'(l4), 512'(e4.last));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && v8 && rdy8) begin
      if (q8.size() == 0) fail("sb8_unexpected_subkey");
      else begin
        e8 = q8.pop_front();
        check("sk8", o8, e8.sk);
        check("idx8", 512'(i8), 512'(e8.idx));
        check("last8", 512'(l8), 512'(e8.last));
      end
    end
  end

  // Called at #1 after a posedge with dut4 idle; ends in the first EMIT cycle.
  task automatic load4(input karr_t k, input logic [63:0] t0, input logic [63:0] t1);
    for (int i = 0; i < 4; i++) key4[(3-i)*64 +: 64] = k[i];
    tw4 = {t0, t1};
    check("idle_load_ready", 512'(lr4), 1);
    push_exp(0, 4, k, t0, t1);
    lv4 = 1;
    @(posedge clk); #1;
    lv4 = 0;
    check("prep_valid", 512'(v4), 0);
    check("prep_busy", 512'(b4), 1);
    check("prep_load_ready", 512'(lr4), 0);
    @(posedge clk); #1;
    check("latency_valid", 512'(v4), 1);
    check("first_index", 512'(i4), 0);
  endtask

  task automatic stream4(input int abort_at, input int rst_at, input bit stall,
                         input bit rnd, input bit hold_ld);
    int           cyc = 0;
    int           st = 0;
    bit           ab_p = 0, last_p = 0, done = 0, was_ab = 0, was_rst = 0;
    logic [255:0] cap = '0;
    logic [4:0]   capi = '0;
    check("emit_load_ready", 512'(lr4), 0);
    if (hold_ld) begin lv4 = 1; key4 = ~key4; end
    while (!done) begin
      if (ab_p) begin
        ab4 = 0;
        check("abort_valid", 512'(v4), 0);
        check("abort_load_ready", 512'(lr4), 1);
        was_ab = 1; done = 1;
      end else if (last_p) begin
        check("done_load_ready", 512'(lr4), 1);
        check("done_valid", 512'(v4), 0);
        done = 1;
      end else if (!v4) begin
        fail("valid_dropped_early");
        done = 1;
      end else if (rst_at == int'(i4)) begin
        rdy4 = 0; rst = 1;
        @(posedge clk); #1;
        check("rst_valid", 512'(v4), 0);
        check("rst_sk_out", {256'b0, o4}, 0);
        check("rst_index", 512'(i4), 0);
        check("rst_last", 512'(l4), 0);
        check("rst_busy", 512'(b4), 0);
        rst = 0;
        check("rst_load_ready", 512'(lr4), 1);
        was_rst = 1; done = 1;
      end else begin
        if (stall && st == 0 && i4 == 5) begin
          cap = o4; capi = i4; rdy4 = 0; st = 1;
        end else if (st >= 1 && st <= 3) begin
          check("stall_sk_hold", {256'b0, o4}, {256'b0, cap});
          check("stall_idx_hold", 512'(i4), 512'(capi));
          if (st == 3) rdy4 = 1;
          st++;
        end else begin
          rdy4 = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        if (hold_ld && l4) lv4 = 0;
        if (rdy4 && int'(i4) == abort_at) begin ab4 = 1; ab_p = 1; end
        else if (rdy4 && l4) last_p = 1;
      end
      if (!done) begin
        @(posedge clk); #1;
        if (++cyc > 400) begin fail("stream_timeout"); done = 1; end
      end
    end
    ab4 = 0; lv4 = 0;
    if (was_ab || was_rst) q4.delete();
    else check("sb4_drained", 512'(q4.size()), 0);
  endtask

  initial begin
    karr_t k;
    int    cyc;
    bit    fin;
    for (int i = 0; i < 16; i++) k[i] = '0;
    repeat (2) @(posedge clk); #1;
    check("reset_valid", 512'(v4), 0);
    check("reset_sk_out", {256'b0, o4}, 0);
    check("reset_index", 512'(i4), 0);
    check("reset_busy", 512'(b4), 0);
    check("reset_sk_out8", o8, 0);
    rst = 0;
    check("post_reset_load_ready", 512'(lr4), 1);

    // all-zero key/tweak, streaming at full rate
    load4(k, 64'd0, 64'd0);
    stream4(-1, -1, 0, 0, 0);

    // small known key, with a competing load held during EMIT
    for (int i = 0; i < 4; i++) k[i] = 64'(i + 1);
    load4(k, 64'd1, 64'd2);
    stream4(-1, -1, 0, 0, 1);
    @(posedge clk); #1;
    check("held_load_not_taken", 512'(b4), 0);

    // backpressure at s=5
    k = rnd_k();
    load4(k, {$urandom, $urandom}, {$urandom, $urandom});
    stream4(-1, -1, 1, 0, 0);

    // abort together with the s=7 handshake, then a clean reload
    k = rnd_k();
    load4(k, {$urandom, $urandom}, {$urandom, $urandom});
    stream4(7, -1, 0, 0, 0);
    k = rnd_k();
    load4(k, {$urandom, $urandom}, {$urandom, $urandom});
    stream4(-1, -1, 0, 1, 0);

    // reset mid-EMIT
    k = rnd_k();
    load4(k, {$urandom, $urandom}, {$urandom, $urandom});
    stream4(-1, 10, 0, 0, 0);

    // NW=8 regression with random key, tweak and ready
    for (int r = 0; r < 2; r++) begin
      logic [63:0] t0, t1;
      k = rnd_k();
      t0 = {$urandom, $urandom};
      t1 = {$urandom, $urandom};
      for (int i = 0; i < 8; i++) key8[(7-i)*64 +: 64] = k[i];
      tw8 = {t0, t1};
      check("ld8_ready", 512'(lr8), 1);
      push_exp(1, 8, k, t0, t1);
      lv8 = 1;
      @(posedge clk); #1;
      lv8 = 0;
      cyc = 0; fin = 0;
      while (!fin) begin
        rdy8 = ($urandom_range(0, 2) != 0);
        fin = v8 && rdy8 && l8;
        @(posedge clk); #1;
        if (++cyc > 400) begin fail("nw8_timeout"); fin = 1; end
      end
      rdy8 = 0;
      check("nw8_done_ready", 512'(lr8), 1);
      check("sb8_drained", 512'(q8.size()), 0);
    end

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
